// File: rtl/nn_pkg.sv
// Shared constants and window/kernel array types for the nn_block datapath.
package nn_pkg;

    localparam int K_SIZE     = 3;
    localparam int W_W        = 8;
    localparam int RES_W      = 24;
    localparam int ACC_FC_W   = 32;
    localparam int SHIFT_NORM = 2;
    localparam int PIX_W      = 9;
    localparam int COEF_W     = 8;

    typedef logic signed [PIX_W-1:0]  window_t [K_SIZE][K_SIZE];
    typedef logic signed [COEF_W-1:0] kernel_t [K_SIZE][K_SIZE];

endpackage

// File: rtl/nn_conv2d.sv
// Combinational K_SIZE x K_SIZE signed multiply-accumulate, doubled, plus bias.
module nn_conv2d
    import nn_pkg::*;
(
    input  window_t                 windowImg,
    input  kernel_t                 kernelCoeff,
    input  logic signed [7:0]       bias,
    output logic signed [RES_W-1:0] conv
);

    logic signed [RES_W-1:0] sum;

    // The 3x3 of 9x8-bit products, doubled, stays well inside RES_W, so no precision is lost here.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < K_SIZE; i++) begin
            for (int unsigned j = 0; j < K_SIZE; j++) begin
                sum = sum + RES_W'(windowImg[i][j]) * RES_W'(kernelCoeff[i][j]);
            end
        end
        conv = (sum <<< 1) + RES_W'(bias);
    end

endmodule

// File: rtl/nn_block.sv
// Two-stage conv -> scale/offset/ReLU -> 3-class FC pipeline.
// Define NN_BLOCK_NORM_SAT_EN to saturate norm_result at the positive RES_W limit instead of wrapping.
module nn_block
    import nn_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  window_t                    windowImg,
    input  kernel_t                    kernelCoeff,
    input  logic signed [7:0]          bias,
    input  logic signed [7:0]          scale,
    input  logic signed [7:0]          offset,
    input  logic signed [W_W-1:0]      weight [3],
    output logic signed [RES_W-1:0]    conv_result,
    output logic signed [RES_W-1:0]    norm_result,
    output logic signed [ACC_FC_W-1:0] acc0,
    output logic signed [ACC_FC_W-1:0] acc1,
    output logic signed [ACC_FC_W-1:0] acc2
);

    localparam int unsigned SHR  = (SHIFT_NORM > 0) ? SHIFT_NORM : 0;
    localparam int unsigned SHL  = (SHIFT_NORM < 0) ? -SHIFT_NORM : 0;
    localparam int          SH_W = RES_W + 8 + SHL;
    localparam int          Q_W  = SH_W + 1;
    localparam logic signed [RES_W-1:0] RES_MAX = {1'b0, {(RES_W-1){1'b1}}};

    logic signed [RES_W-1:0]    conv_next;
    logic signed [7:0]          scale_r;
    logic signed [7:0]          offset_r;
    logic signed [W_W-1:0]      weight_r [3];
    logic signed [SH_W-1:0]     p;
    logic signed [SH_W-1:0]     ps;
    logic signed [Q_W-1:0]      q;
    logic signed [RES_W-1:0]    norm_next;
    logic signed [ACC_FC_W-1:0] acc_next [3];

    nn_conv2d u_conv (
        .windowImg   (windowImg),
        .kernelCoeff (kernelCoeff),
        .bias        (bias),
        .conv        (conv_next)
    );

    // Stage-2 operands travel with their sample so back-to-back inputs never mix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conv_result <= '0;
            scale_r     <= '0;
            offset_r    <= '0;
            for (int unsigned c = 0; c < 3; c++) weight_r[c] <= '0;
        end else begin
            conv_result <= conv_next;
            scale_r     <= scale;
            offset_r    <= offset;
            for (int unsigned c = 0; c < 3; c++) weight_r[c] <= weight[c];
        end
    end

    always_comb begin
        p  = SH_W'(conv_result) * SH_W'(scale_r);
        ps = (p >>> SHR) <<< SHL;
        q  = Q_W'(ps) + Q_W'(offset_r);
        if (q[Q_W-1]) begin
            norm_next = '0;
`ifdef NN_BLOCK_NORM_SAT_EN
        end else if (q > Q_W'(RES_MAX)) begin
            norm_next = RES_MAX;
`endif
        end else begin
            norm_next = q[RES_W-1:0];
        end
        for (int unsigned c = 0; c < 3; c++) begin
            acc_next[c] = ACC_FC_W'(norm_next) * ACC_FC_W'(weight_r[c]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            norm_result <= '0;
            acc0        <= '0;
            acc1        <= '0;
            acc2        <= '0;
        end else begin
            norm_result <= norm_next;
            acc0        <= acc_next[0];
            acc1        <= acc_next[1];
            acc2        <= acc_next[2];
        end
    end

endmodule

// File: tb/tb_nn_block.sv
// Directed-vector bench for nn_block with hand-computed expectations.
module tb_nn_block;
    import nn_pkg::*;

    logic                       clk;
    logic                       rst;
    window_t                    windowImg;
    kernel_t                    kernelCoeff;
    logic signed [7:0]          bias;
    logic signed [7:0]          scale;
    logic signed [7:0]          offset;
    logic signed [W_W-1:0]      weight [3];
    logic signed [RES_W-1:0]    conv_result;
    logic signed [RES_W-1:0]    norm_result;
    logic signed [ACC_FC_W-1:0] acc0;
    logic signed [ACC_FC_W-1:0] acc1;
    logic signed [ACC_FC_W-1:0] acc2;

    int n_vec;
    int n_err;
    int wv [9];
    int kv [9];

    nn_block dut (
        .clk         (clk),
        .rst         (rst),
        .windowImg   (windowImg),
        .kernelCoeff (kernelCoeff),
        .bias        (bias),
        .scale       (scale),
        .offset      (offset),
        .weight      (weight),
        .conv_result (conv_result),
        .norm_result (norm_result),
        .acc0        (acc0),
        .acc1        (acc1),
        .acc2        (acc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int b, input int s, input int o, input int w0, input int w1, input int w2);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                windowImg[i][j]   = 9'(wv[i*3+j]);
                kernelCoeff[i][j] = 8'(kv[i*3+j]);
            end
        end
        bias      = 8'(b);
        scale     = 8'(s);
        offset    = 8'(o);
        weight[0] = 8'(w0);
        weight[1] = 8'(w1);
        weight[2] = 8'(w2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int c, input int n, input int a0, input int a1, input int a2);
        chk({tag, ".conv"}, conv_result, c);
        chk({tag, ".norm"}, norm_result, n);
        chk({tag, ".acc0"}, acc0, a0);
        chk({tag, ".acc1"}, acc1, a1);
        chk({tag, ".acc2"}, acc2, a2);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        wv = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        kv = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(0, 0, 0, 0, 0, 0);
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b1;

        // Basic: S=45, conv=90, P=180>>>2=45, +4=49
        wv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        kv = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        drive(0, 2, 4, 1, 2, 3);
        tick();
        tick();
        chk_all("v1", 90, 49, 49, 98, 147);

        // S=0, conv=10, P=-10>>>2=-3 (floor), +3=0
        wv = '{-1, 2, -3, 4, -5, 6, -7, 8, -9};
        kv = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
        drive(10, -1, 3, 2, 4, 6);
        tick();
        tick();
        chk_all("v2", 10, 0, 0, 0, 0);

        // Q=-23 clipped by ReLU
        wv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        kv = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        drive(0, -1, 0, 5, -3, 7);
        tick();
        tick();
        chk_all("v3", 90, 0, 0, 0, 0);

        // Negative conv, negative scale: conv=-95, P=285>>>2=71, +7=78
        kv = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
        drive(-5, -3, 7, -2, 1, 4);
        tick();
        tick();
        chk_all("v4", -95, 78, -156, 78, 312);

        // Extreme inputs: Q=18512186 overflows RES_W
        wv = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        kv = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
        drive(127, 127, 127, 1, -1, 0);
        tick();
        tick();
`ifdef NN_BLOCK_NORM_SAT_EN
        chk_all("ovf", 583057, 8388607, 8388607, -8388607, 0);
`else
        chk_all("ovf", 583057, 1734970, 1734970, -1734970, 0);
`endif

        // Mid-stream asynchronous reset, then latency after release
        wv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        kv = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        drive(0, 2, 4, 1, 2, 3);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk_all("rst_async", 0, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        tick();
        chk_all("rel_e1", 90, 0, 0, 0, 0);
        tick();
        chk_all("rel_e2", 90, 49, 49, 98, 147);

        // Back-to-back samples: v1 -> v4 -> small sample
        wv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        kv = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
        drive(-5, -3, 7, -2, 1, 4);
        tick();
        chk_all("b2b_1", -95, 49, 49, 98, 147);
        // conv=7, P=7>>>2=1, Q=1
        wv = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(7, 1, 0, 3, -1, 0);
        tick();
        chk_all("b2b_2", 7, 78, -156, 78, 312);
        tick();
        chk_all("b2b_3", 7, 1, 3, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
